// File: rtl/univ_shift_deser.sv
// Serial-in / parallel-out deserializer with a one-deep valid/ready output register.
// Optional even-parity bit after each word when USR_DESER_PARITY_EN is defined.
module univ_shift_deser #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] op,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             overrun,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             parity_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] word;
  logic             dir_q;
  logic             shift_dir;
  logic             accept;
  logic             complete;
  logic             perr;
  logic             last_data;

  assign busy      = (state != IDLE);
  assign accept    = sin_valid && !clr;
  assign last_data = (bit_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    // The first bit of a word uses the live direction input; dir_q is latched on that same edge.
    shift_dir = (state == IDLE) ? lsb_first : dir_q;
    sr_next   = shift_dir ? {sin, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sin};
`ifdef USR_DESER_PARITY_EN
    complete  = accept && (state == PAR);
    word      = sr;
    perr      = (^sr) ^ sin;
`else
    complete  = accept && (state == SHIFT) && last_data;
    word      = sr_next;
    perr      = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      state      <= IDLE;
      sr         <= '0;
      dir_q      <= 1'b0;
      bit_cnt    <= '0;
      op         <= '0;
      op_valid   <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (op_valid && op_ready)
        op_valid <= 1'b0;

      if (complete) begin
        if (!op_valid || op_ready) begin
          op         <= word;
          op_valid   <= 1'b1;
          parity_err <= perr;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (clr) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else if (sin_valid) begin
        case (state)
          IDLE: begin
            sr      <= sr_next;
            dir_q   <= lsb_first;
            bit_cnt <= CNT_W'(1);
            state   <= SHIFT;
          end
          SHIFT: begin
            sr <= sr_next;
            if (last_data) begin
`ifdef USR_DESER_PARITY_EN
              state   <= PAR;
              bit_cnt <= CNT_W'(WIDTH);
`else
              state   <= IDLE;
              bit_cnt <= '0;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          PAR: begin
            state   <= IDLE;
            bit_cnt <= '0;
          end
          default: begin
            state   <= IDLE;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
